bh_run_ctrl: RTL
================

Name: bh_run_ctrl

Overview:
- Synthesizable run controller for the BrainHack system: boots a BrainHack core in hardware, where the simulation harness did it with preloads and a fixed timeout.
- Sequence: clear tape RAM, stream program words into program memory over a valid/ready handshake, release the core, then stop it on halt or when a cycle budget runs out.
- Sits between a host byte/word stream and the tape RAM, program memory and core.

Parameters:
- TAPE_ADDR_W, 8, tape RAM address width (depth 2^TAPE_ADDR_W)
- TAPE_DATA_W, 8, tape cell width
- PRG_ADDR_W, 8, program memory address width (depth 2^PRG_ADDR_W)
- INSTR_W, 4, instruction width
- CYC_W, 16, cycle counter / limit width

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  start pulse; sampled only in IDLE or DONE
- i_cycle_limit  in  CYC_W  run budget in cycles; 0 = unlimited
- i_prg_valid  in  1  program word valid
- o_prg_ready  out  1  program word accepted when valid&ready
- i_prg_data  in  INSTR_W  program word
- i_prg_last  in  1  marks final program word
- o_prg_we  out  1  program memory write enable
- o_prg_addr  out  PRG_ADDR_W  program memory write address
- o_prg_wdata  out  INSTR_W  program memory write data
- o_tape_we  out  1  tape write enable (controller phases only)
- o_tape_addr  out  TAPE_ADDR_W  tape write address
- o_tape_wdata  out  TAPE_DATA_W  tape write data
- i_core_halt  in  1  core reports halt
- o_core_run  out  1  core enable; core holds all state when low
- o_busy  out  1  high in CLEAR/LOAD/RUN
- o_done  out  1  high in DONE
- o_timeout  out  1  valid in DONE: run ended by budget
- o_prg_len  out  PRG_ADDR_W+1  words loaded
- o_cycles  out  CYC_W  cycles spent in RUN

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0; counters 0. Reset mid-operation aborts immediately. Memories are not restored.
- FSM: IDLE -> CLEAR -> LOAD -> RUN -> DONE; DONE --i_start--> CLEAR.
- IDLE: wait for i_start; start is registered, so CLEAR begins the next cycle.
- CLEAR:
  - o_tape_we=1, o_tape_wdata=0, o_tape_addr counts 0 to 2^TAPE_ADDR_W-1, one cell per cycle.
  - Exactly 2^TAPE_ADDR_W cycles; then go to LOAD.
- LOAD:
  - o_prg_ready=1 while address counter is below depth.
  - On each handshake: o_prg_we=1 combinationally in the same cycle, with o_prg_addr=counter and o_prg_wdata=i_prg_data; the counter increments.
  - Leave to RUN after the handshake carrying i_prg_last, or after the word written at address 2^PRG_ADDR_W-1 (full). Extra words are never accepted.
  - o_prg_len = words accepted (1..2^PRG_ADDR_W).
  - A valid that is held low stalls LOAD indefinitely.
- RUN:
  - o_core_run=1; o_cycles increments each RUN cycle, starting from 0.
  - i_core_halt=1 -> DONE, o_timeout=0.
  - Else, if i_cycle_limit!=0 and o_cycles+1==i_cycle_limit -> DONE, o_timeout=1. The run therefore lasts exactly i_cycle_limit cycles.
  - If halt and limit coincide, halt wins (o_timeout=0).
  - With limit 0, o_cycles saturates at all-ones.
  - i_cycle_limit is sampled at RUN entry.
- DONE: o_core_run=0; o_done=1; o_cycles, o_timeout and o_prg_len are held until the next i_start.
- Ignored inputs:
  - i_start during CLEAR/LOAD/RUN.
  - i_core_halt outside RUN.
  - i_prg_valid outside LOAD (o_prg_ready=0).
- Tape port: controller drives o_tape_we only in CLEAR (and PRELOAD); 0 elsewhere, so core tape writes have the port during RUN.

Optional Feature:
- Macro BH_TAPE_PRELOAD_EN.
- Defined:
  - Adds ports i_tape_valid, o_tape_ready, i_tape_data[TAPE_DATA_W], i_tape_last.
  - Adds state PRELOAD between CLEAR and LOAD.
  - Each handshake writes i_tape_data to tape starting at address 0, incrementing.
  - Exit on i_tape_last or on the last cell.
  - i_tape_last asserted with i_tape_valid=0 in the first PRELOAD cycle skips preload.
- Undefined: ports absent; CLEAR goes directly to LOAD.

Decomposition:
- Shared package/header: state encoding constants (IDLE, CLEAR, PRELOAD, LOAD, RUN, DONE), default widths equal to the system width macros (tape addr/data, prgmem addr, instr).
- One sub-module: bh_sat_counter (parametrised width, clear, enable, saturate), used for the cycle count.
- The address counters stay inline.

Test Plan:
- Reset mid-LOAD (i_reset_n=0 after 3 words): all outputs 0 asynchronously; next i_start gives a full CLEAR again.
- TAPE_ADDR_W=3, i_start: 8 tape writes of 0 at addresses 0..7, then o_prg_ready=1 in the next cycle.
- Stream 5 words with a valid gap after word 2, last on word 5: writes at addr 0..4, o_prg_len=5, RUN entered next cycle.
- PRG_ADDR_W=2, 6 valid words, last never asserted: 4 accepted, ready drops, RUN entered.
- i_cycle_limit=10, halt never asserted: o_core_run high exactly 10 cycles; DONE with o_timeout=1, o_cycles=10.
- Halt asserted in cycle 4 of RUN with limit 4: DONE, o_timeout=0. Then i_start restarts from CLEAR.

Source files
------------

// File: rtl/bh_run_ctrl_pkg.sv
// Shared definitions for the BrainHack run controller: default system widths and FSM state encoding.
package bh_run_ctrl_pkg;

  localparam int BH_TAPE_ADDR_W = 8;
  localparam int BH_TAPE_DATA_W = 8;
  localparam int BH_PRG_ADDR_W  = 8;
  localparam int BH_INSTR_W     = 4;
  localparam int BH_CYC_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PRELOAD = 3'd2,
    ST_LOAD    = 3'd3,
    ST_RUN     = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/bh_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module bh_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/bh_run_ctrl.sv
// BrainHack run controller: clears tape, loads program words, runs the core until halt or budget.
// Optional tape preload phase is enabled by defining BH_TAPE_PRELOAD_EN.
module bh_run_ctrl
  import bh_run_ctrl_pkg::*;
#(
  parameter int TAPE_ADDR_W = BH_TAPE_ADDR_W,
  parameter int TAPE_DATA_W = BH_TAPE_DATA_W,
  parameter int PRG_ADDR_W  = BH_PRG_ADDR_W,
  parameter int INSTR_W     = BH_INSTR_W,
  parameter int CYC_W       = BH_CYC_W
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic [CYC_W-1:0]       i_cycle_limit,
  input  logic                   i_prg_valid,
  output logic                   o_prg_ready,
  input  logic [INSTR_W-1:0]     i_prg_data,
  input  logic                   i_prg_last,
  output logic                   o_prg_we,
  output logic [PRG_ADDR_W-1:0]  o_prg_addr,
  output logic [INSTR_W-1:0]     o_prg_wdata,
  output logic                   o_tape_we,
  output logic [TAPE_ADDR_W-1:0] o_tape_addr,
  output logic [TAPE_DATA_W-1:0] o_tape_wdata,
`ifdef BH_TAPE_PRELOAD_EN
  input  logic                   i_tape_valid,
  output logic                   o_tape_ready,
  input  logic [TAPE_DATA_W-1:0] i_tape_data,
  input  logic                   i_tape_last,
`endif
  input  logic                   i_core_halt,
  output logic                   o_core_run,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_timeout,
  output logic [PRG_ADDR_W:0]    o_prg_len,
  output logic [CYC_W-1:0]       o_cycles
);

  state_e                 r_state;
  state_e                 w_next;
  logic [TAPE_ADDR_W-1:0] r_tape_cnt;
  logic [PRG_ADDR_W:0]    r_prg_cnt;
  logic [CYC_W-1:0]       r_limit;
  logic                   r_timeout;
  logic [CYC_W-1:0]       w_cycles;

  logic w_start;
  logic w_clear_last;
  logic w_tape_step;
  logic w_prg_hs;
  logic w_prg_full;
  logic w_load_exit;
  logic w_halt;
  logic w_budget;

  assign w_start      = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_clear_last = (r_state == ST_CLEAR) && (r_tape_cnt == '1);

  // Program counter carries one extra bit so a full memory reads back as length 2^PRG_ADDR_W.
  assign w_prg_hs    = (r_state == ST_LOAD) && !r_prg_cnt[PRG_ADDR_W] && i_prg_valid;
  assign w_prg_full  = (r_prg_cnt[PRG_ADDR_W-1:0] == '1);
  assign w_load_exit = w_prg_hs && (i_prg_last || w_prg_full);

  assign w_halt   = (r_state == ST_RUN) && i_core_halt;
  assign w_budget = (r_state == ST_RUN) && (r_limit != '0) &&
                    ((w_cycles + CYC_W'(1)) == r_limit);

`ifdef BH_TAPE_PRELOAD_EN
  logic r_pre_first;
  logic w_tape_hs;
  logic w_pre_exit;

  assign w_tape_hs   = (r_state == ST_PRELOAD) && i_tape_valid;
  assign w_pre_exit  = (w_tape_hs && (i_tape_last || (r_tape_cnt == '1))) ||
                       (r_pre_first && i_tape_last && !i_tape_valid);
  assign w_tape_step = (r_state == ST_CLEAR) || w_tape_hs;

  // Only the very first PRELOAD cycle may skip preload with a bare last.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pre_first <= 1'b0;
    end else begin
      r_pre_first <= w_clear_last;
    end
  end
`else
  assign w_tape_step = (r_state == ST_CLEAR);
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_start)      w_next = ST_CLEAR;
`ifdef BH_TAPE_PRELOAD_EN
      ST_CLEAR:         if (w_clear_last) w_next = ST_PRELOAD;
      ST_PRELOAD:       if (w_pre_exit)   w_next = ST_LOAD;
`else
      ST_CLEAR:         if (w_clear_last) w_next = ST_LOAD;
`endif
      ST_LOAD:          if (w_load_exit)  w_next = ST_RUN;
      ST_RUN:           if (w_halt || w_budget) w_next = ST_DONE;
      default:          w_next = ST_IDLE;
    endcase
  end

  // NOTE: only control registers are reset; tape and program memories keep their contents.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tape_cnt <= '0;
      r_prg_cnt  <= '0;
      r_limit    <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_start) begin
        r_tape_cnt <= '0;
        r_prg_cnt  <= '0;
        r_timeout  <= 1'b0;
      end else begin
        if (w_tape_step) r_tape_cnt <= r_tape_cnt + 1'b1;
        if (w_prg_hs)    r_prg_cnt  <= r_prg_cnt + 1'b1;
        if (w_budget && !w_halt) r_timeout <= 1'b1;
      end
      if (w_load_exit) r_limit <= i_cycle_limit;
    end
  end

  bh_sat_counter #(
    .WIDTH (CYC_W)
  ) u_cycle_cnt (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (w_start),
    .i_en      (r_state == ST_RUN),
    .o_count   (w_cycles)
  );

  always_comb begin
    o_prg_ready  = 1'b0;
    o_prg_we     = 1'b0;
    o_prg_addr   = '0;
    o_prg_wdata  = '0;
    o_tape_we    = 1'b0;
    o_tape_addr  = '0;
    o_tape_wdata = '0;
    o_core_run   = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
`ifdef BH_TAPE_PRELOAD_EN
    o_tape_ready = 1'b0;
`endif
    case (r_state)
      ST_CLEAR: begin
        o_busy      = 1'b1;
        o_tape_we   = 1'b1;
        o_tape_addr = r_tape_cnt;
      end
`ifdef BH_TAPE_PRELOAD_EN
      ST_PRELOAD: begin
        o_busy       = 1'b1;
        o_tape_ready = 1'b1;
        if (w_tape_hs) begin
          o_tape_we    = 1'b1;
          o_tape_addr  = r_tape_cnt;
          o_tape_wdata = i_tape_data;
        end
      end
`endif
      ST_LOAD: begin
        o_busy      = 1'b1;
        o_prg_ready = !r_prg_cnt[PRG_ADDR_W];
        if (w_prg_hs) begin
          o_prg_we    = 1'b1;
          o_prg_addr  = r_prg_cnt[PRG_ADDR_W-1:0];
          o_prg_wdata = i_prg_data;
        end
      end
      ST_RUN: begin
        o_busy     = 1'b1;
        o_core_run = 1'b1;
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_timeout = r_timeout;
  assign o_prg_len = r_prg_cnt;
  assign o_cycles  = w_cycles;

endmodule
